// File: rtl/watermark_embedder_core.sv
// watermark_embedder_core
//   Streaming bit-plane watermark embedder. Each host pixel accepted on s_*
//   leaves on m_* one cycle later with bit BIT_POS replaced by
//   wm[cnt mod WM_BITS], so the stored watermark tiles the image in raster order.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   start / done / busy  job control (start pulse, one-cycle done, busy != IDLE)
//   wm_wr_*              watermark bit write port (honoured in IDLE only)
//   s_valid/s_ready/s_pixel          host pixel input stream
//   m_valid/m_ready/m_pixel/m_last   watermarked pixel output stream
module watermark_embedder_core #(
  parameter int PIX_W      = 8,
  parameter int IMG_PIXELS = 65536,
  parameter int WM_BITS    = 1024,
  parameter int BIT_POS    = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       done,
  output logic                       busy,
  input  logic                       wm_wr_en,
  input  logic [$clog2(WM_BITS)-1:0] wm_wr_addr,
  input  logic                       wm_wr_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [PIX_W-1:0]           s_pixel,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [PIX_W-1:0]           m_pixel,
  output logic                       m_last
);

  localparam int IW = $clog2(WM_BITS);
  localparam int CW = $clog2(IMG_PIXELS + 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [WM_BITS-1:0] wm;
  logic [IW-1:0]     wm_idx;
  logic              accept;
  logic              last_pix;
  logic [PIX_W-1:0]  pix_emb;

  // WM_BITS is a power of two, so cnt mod WM_BITS is just the low bits of cnt.
  // A small image with a large watermark can leave cnt narrower than the index.
  generate
    if (CW >= IW) begin : g_idx_slice
      assign wm_idx = cnt[IW-1:0];
    end else begin : g_idx_ext
      assign wm_idx = {{(IW-CW){1'b0}}, cnt};
    end
  endgenerate

  assign last_pix = (cnt == CW'(IMG_PIXELS - 1));
  assign accept   = s_valid && s_ready;

  always_comb begin
    pix_emb          = s_pixel;
    pix_emb[BIT_POS] = wm[wm_idx];
  end

  // Watermark storage: not reset, frozen while a job is in progress.
  always_ff @(posedge clk) begin
    if (state == IDLE && wm_wr_en)
      wm[wm_wr_addr] <= wm_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        // Single output register: refill in the same cycle it drains.
        s_ready = !m_valid || m_ready;
        if (s_valid && (!m_valid || m_ready) && last_pix) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (m_valid && m_ready && m_last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      m_valid <= 1'b0;
      m_pixel <= '0;
      m_last  <= 1'b0;
    end else begin
      if (state == IDLE && start) cnt <= '0;
      if (accept) begin
        m_pixel <= pix_emb;
        m_valid <= 1'b1;
        m_last  <= last_pix;
        cnt     <= cnt + CW'(1);
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_watermark_embedder_core.sv
module tb_watermark_embedder_core;
  localparam int NP = 8;
  localparam int WB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, wm_wr_en, wm_wr_data, s_valid, m_ready;
  logic [1:0] wm_wr_addr;
  logic [7:0] s_pixel, m_pixel;
  logic       done, busy, s_ready, m_valid, m_last;

  logic       start7, wm_wr_en7, wm_wr_data7, s_valid7, m_ready7;
  logic [1:0] wm_wr_addr7;
  logic [7:0] s_pixel7, m_pixel7;
  logic       done7, busy7, s_ready7, m_valid7, m_last7;

  watermark_embedder_core #(.PIX_W(8), .IMG_PIXELS(NP), .WM_BITS(WB), .BIT_POS(0)) dut (
    .clk(clk), .rst(rst), .start(start), .done(done), .busy(busy),
    .wm_wr_en(wm_wr_en), .wm_wr_addr(wm_wr_addr), .wm_wr_data(wm_wr_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel),
    .m_valid(m_valid), .m_ready(m_ready), .m_pixel(m_pixel), .m_last(m_last));

  watermark_embedder_core #(.PIX_W(8), .IMG_PIXELS(NP), .WM_BITS(WB), .BIT_POS(7)) dut7 (
    .clk(clk), .rst(rst), .start(start7), .done(done7), .busy(busy7),
    .wm_wr_en(wm_wr_en7), .wm_wr_addr(wm_wr_addr7), .wm_wr_data(wm_wr_data7),
    .s_valid(s_valid7), .s_ready(s_ready7), .s_pixel(s_pixel7),
    .m_valid(m_valid7), .m_ready(m_ready7), .m_pixel(m_pixel7), .m_last(m_last7));

  int checks = 0;
  int failures = 0;

  // Reference model: watermark contents, expected outputs in flight, job progress.
  bit         wm_m [WB];
  logic [7:0] expq [$];
  logic [7:0] pix  [NP];
  bit         in_job, done_due, saw_done, prev_stall, prev_last;
  int         in_cnt, out_cnt;
  logic [7:0] prev_pix;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] embed0(input logic [7:0] p, input bit b);
    return (p & 8'hFE) | {7'd0, b};
  endfunction

  task automatic model_reset();
    expq.delete();
    in_job = 0; done_due = 0; saw_done = 0; prev_stall = 0;
    in_cnt = 0; out_cnt = 0;
  endtask

  // One clock of the main DUT: drive at negedge, check, then advance the model
  // to what the coming rising edge should do.
  task automatic cyc(input bit sv, input logic [7:0] px, input bit mr, input bit st,
                     input bit we, input logic [1:0] wa, input bit wd);
    bit was_idle, run_ok, ohs, acc, old_done;
    @(negedge clk);
    s_valid = sv; s_pixel = px; m_ready = mr; start = st;
    wm_wr_en = we; wm_wr_addr = wa; wm_wr_data = wd;
    #1;
    was_idle = !in_job;
    run_ok   = in_job && (in_cnt < NP);
    chk("m_valid", m_valid, expq.size() != 0);
    chk("busy", busy, in_job);
    chk("done", done, done_due);
    if (prev_stall) begin
      chk("hold_pixel", m_pixel, prev_pix);
      chk("hold_last", m_last, prev_last);
    end
    if (run_ok) chk("s_ready_run", s_ready, (expq.size() == 0) || mr);
    else        chk("s_ready_off", s_ready, 0);
    ohs = m_valid && mr;
    if (ohs && expq.size() != 0) begin
      chk("m_pixel", m_pixel, expq[0]);
      chk("m_last", m_last, out_cnt == NP - 1);
      void'(expq.pop_front());
      out_cnt++;
    end
    acc = sv && s_ready && run_ok;
    if (acc) begin
      expq.push_back(embed0(px, wm_m[in_cnt % WB]));
      in_cnt++;
    end
    old_done   = done_due;
    saw_done   = old_done;
    done_due   = ohs && in_job && (out_cnt == NP) && (in_cnt == NP) && !old_done;
    if (old_done) in_job = 0;
    if (was_idle) begin
      if (we) wm_m[wa] = wd;
      if (st) begin in_job = 1; in_cnt = 0; out_cnt = 0; end
    end
    prev_stall = m_valid && !mr;
    prev_pix   = m_pixel;
    prev_last  = m_last;
  endtask

  // mode 0: full rate, ramp pixels; 1: m_ready 1,0,0,1 ramp pixels; 2: random.
  task automatic job(input int mode, input bit inject, input int abort_at, input bit start_wr);
    bit mr, sv, fin;
    logic [7:0] px;
    for (int i = 0; i < NP; i++) pix[i] = (mode == 2) ? 8'($urandom) : 8'(i);
    cyc(0, 8'h00, 1, 1, start_wr, 2'd1, ~wm_m[1]);
    fin = 0;
    for (int t = 0; t < 200 && !fin; t++) begin
      case (mode)
        1:       mr = (t % 4 == 0) || (t % 4 == 3);
        2:       mr = 1'($urandom_range(0, 1));
        default: mr = 1;
      endcase
      sv = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      px = (in_cnt < NP) ? pix[in_cnt] : 8'h00;
      cyc(sv, px, mr, inject && t == 2, inject && t == 2, 2'd0, 1'b0);
      if (abort_at > 0 && in_cnt == abort_at) fin = 1;
      if (saw_done) fin = 1;
    end
    if (!fin) chk("job_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; start = 0; s_valid = 0; wm_wr_en = 0; m_ready = 1;
    @(negedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_m_pixel", m_pixel, 0);
    chk("rst_m_last", m_last, 0);
    rst = 0;
    model_reset();
  endtask

  logic [7:0] p7 [8];
  logic [7:0] e7 [8];
  bit         w7 [4];

  initial begin
    rst = 1; start = 0; wm_wr_en = 0; wm_wr_addr = 0; wm_wr_data = 0;
    s_valid = 0; s_pixel = 0; m_ready = 1;
    start7 = 0; wm_wr_en7 = 0; wm_wr_addr7 = 0; wm_wr_data7 = 0;
    s_valid7 = 0; s_pixel7 = 0; m_ready7 = 1;
    for (int i = 0; i < WB; i++) wm_m[i] = 0;
    model_reset();
    @(negedge clk);
    do_reset();
    chk("rst_busy7", busy7, 0);
    chk("rst_m_valid7", m_valid7, 0);

    // Bit 7 plane on the second instance, watermark {1,1,0,1}.
    w7 = '{1, 1, 0, 1};
    p7 = '{8'hFE, 8'h7F, 8'h80, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    e7 = '{8'hFE, 8'hFF, 8'h00, 8'h80, 8'h91, 8'hA2, 8'h33, 8'hC4};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wm_wr_en7 = 1; wm_wr_addr7 = 2'(i); wm_wr_data7 = w7[i];
    end
    @(negedge clk);
    wm_wr_en7 = 0; start7 = 1;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      start7 = 0;
      s_valid7 = (i < 8);
      s_pixel7 = (i < 8) ? p7[i] : 8'h00;
      #1;
      if (i < 8) chk("b7_s_ready", s_ready7, 1);
      if (i > 0) begin
        chk("b7_m_valid", m_valid7, 1);
        chk("b7_m_pixel", m_pixel7, e7[i-1]);
        chk("b7_m_last", m_last7, i == 8);
      end
    end
    @(negedge clk);
    s_valid7 = 0;
    #1;
    chk("b7_done", done7, 1);
    chk("b7_m_valid_clr", m_valid7, 0);
    @(negedge clk);
    #1;
    chk("b7_done_clr", done7, 0);
    chk("b7_busy_clr", busy7, 0);

    // Load {1,0,1,1} and stream at full rate.
    cyc(0, 8'h00, 1, 0, 1, 2'd0, 1);
    cyc(0, 8'h00, 1, 0, 1, 2'd1, 0);
    cyc(0, 8'h00, 1, 0, 1, 2'd2, 1);
    cyc(0, 8'h00, 1, 0, 1, 2'd3, 1);
    job(0, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0, 2'd0, 0);
    chk("idle_after_job", busy, 0);

    // Output backpressure 1,0,0,1.
    job(1, 0, 0, 0);
    // Write attempt and restart attempt mid-job are ignored.
    job(0, 1, 0, 0);
    chk("wm0_kept", wm_m[0], 1);
    // Reset after three accepts, then a full job with the watermark intact.
    job(0, 0, 3, 0);
    do_reset();
    job(0, 0, 0, 0);
    // Back-to-back: random jobs, each started the cycle after the previous done;
    // one of them writes wm[1] in its start cycle.
    job(2, 0, 0, 0);
    job(2, 0, 0, 1);
    job(1, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0, 2'd0, 0);
    chk("final_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
